// File: rtl/gf569_pkg.sv
// Shared constants, state encoding and helpers for the GF(569) inverse unit.
package gf569_pkg;

    localparam int Q  = 569;
    localparam int MU = 1842;
    localparam int K  = 10;
    localparam int W  = 10;

    localparam logic [W-1:0] EXP = 10'd567;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } state_t;

    function automatic logic [11:0] csub(input logic [11:0] v);
        return (v >= 12'(Q)) ? v - 12'(Q) : v;
    endfunction

endpackage

// File: rtl/gf569_mulmod.sv
// Combinational Barrett multiply-reduce: r = x*y mod 569 for x, y < 569.
module gf569_mulmod
    import gf569_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] r
);

    logic [18:0] w_p;
    logic [20:0] w_t;
    logic [9:0]  w_q;
    logic [18:0] w_qm;
    logic [11:0] w_r0;
    logic [11:0] w_r1;
    logic [11:0] w_r2;

    assign w_p  = {9'd0, x} * {9'd0, y};
    assign w_t  = {12'd0, w_p[18:K]} * 21'(MU);
    assign w_q  = 10'(w_t >> K);
    assign w_qm = {9'd0, w_q} * 19'(Q);
    assign w_r0 = 12'(w_p - w_qm);

    // Truncating p before the MU multiply lets q fall up to three short.
    assign w_r1 = csub(w_r0);
    assign w_r2 = csub(w_r1);
    assign r    = 10'(csub(w_r2));

endmodule

// File: rtl/gf569_inverse.sv
// Fermat inversion a^567 mod 569 by MSB-first square-and-multiply,
// one shared Barrett multiply-reduce per cycle behind valid/ready.
module gf569_inverse
    import gf569_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout_r,
    output logic         dout_err
);

    state_t      r_state;
    state_t      w_next;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_base;
    logic [3:0]   r_idx;
    logic         r_err;

    logic [W-1:0] w_a;
    logic [W-1:0] w_y;
    logic [W-1:0] w_mm;
    logic         w_bit;
    logic         w_last;

    assign w_a    = (din_a >= 10'(Q)) ? din_a - 10'(Q) : din_a;
    assign w_y    = (r_state == MUL) ? r_base : r_acc;
    assign w_bit  = EXP[r_idx];
    assign w_last = (r_idx == 4'd0);

    gf569_mulmod u_mulmod (
        .x (r_acc),
        .y (w_y),
        .r (w_mm)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_next = SQR;
            SQR: begin
                if (w_bit)       w_next = MUL;
                else if (w_last) w_next = DONE;
            end
            MUL:  w_next = w_last ? DONE : SQR;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_base  <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc  <= w_a;
                        r_base <= w_a;
                        r_idx  <= 4'd8;
                        r_err  <= (w_a == '0);
                    end
                end
                SQR: begin
                    r_acc <= w_mm;
                    if (!w_bit && !w_last) r_idx <= r_idx - 4'd1;
                end
                MUL: begin
                    r_acc <= w_mm;
                    if (!w_last) r_idx <= r_idx - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign dout_r    = r_acc;
    assign dout_err  = r_err;

endmodule

// File: tb/tb_gf569_inverse.sv
// Self-checking bench for gf569_inverse: vector table, scoreboard, corner sequences.
module tb_gf569_inverse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] din_a = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] dout_r;
    logic       dout_err;

    gf569_inverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_r    (dout_r),
        .dout_err  (dout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int r;
        bit err;
    } vec_t;

    typedef struct {
        int r;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t vecs[8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int e0 = 0;
    int cons_edge = -100;
    int held_r = 0;
    bit seen = 0;
    bit gap_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int inv_model(input int a);
        int v;
        v = a % 569;
        if (v == 0) return 0;
        for (int b = 1; b < 569; b++)
            if ((v * b) % 569 == 1) return b;
        return -1;
    endfunction

    // Monitor: samples on the falling edge, inputs change 1 ns after rising.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (in_valid && in_ready) begin
                e0 = cyc + 1;
                if (gap_chk) begin
                    chk("accept_gap", e0, cons_edge + 1);
                    gap_chk = 0;
                end
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    held_r = int'(dout_r);
                    chk("latency", cyc - e0, 14);
                end else begin
                    chk("hold_r", int'(dout_r), held_r);
                end
                chk("in_ready_busy", int'(in_ready), 0);
                if (out_ready) begin
                    seen = 0;
                    cons_edge = cyc + 1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: got result %0d, want none", dout_r);
                    end else begin
                        m_e = sb.pop_front();
                        chk("dout_r", int'(dout_r), m_e.r);
                        chk("dout_err", int'(dout_err), int'(m_e.err));
                    end
                end
            end
        end
    end

    task automatic send(input int a, input int r, input bit e);
        int n;
        n = 0;
        in_valid = 1'b1;
        din_a = 10'(a);
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0, want 1 for a=%0d", a);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{r, e});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = out_valid;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: got out_valid 0, want 1");
        end
    endtask

    task automatic recv(input int bp);
        bit ok;
        out_ready = (bp == 0);
        wait_valid(ok);
        if (!ok) return;
        repeat (bp) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input int a, input int r, input bit e, input int bp);
        send(a, r, e);
        recv(bp);
    endtask

    initial begin
        bit ok;

        vecs[0] = '{2,    285, 1'b0};
        vecs[1] = '{1,    1,   1'b0};
        vecs[2] = '{568,  568, 1'b0};
        vecs[3] = '{7,    244, 1'b0};
        vecs[4] = '{0,    0,   1'b1};
        vecs[5] = '{569,  0,   1'b1};
        vecs[6] = '{571,  285, 1'b0};
        vecs[7] = '{1023, inv_model(454), 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout_r", int'(dout_r), 0);
        chk("rst_dout_err", int'(dout_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            run(vecs[i].a, vecs[i].r, vecs[i].err, 0);

        // Back-pressure with the next operand already waiting.
        send(2, 285, 1'b0);
        out_ready = 1'b0;
        wait_valid(ok);
        in_valid = 1'b1;
        din_a = 10'd7;
        gap_chk = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(7, 244, 1'b0);
        recv(0);
        chk("gap_checked", int'(gap_chk), 0);

        // Abort an inversion with reset on step edge E7.
        send(5, inv_model(5), 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_dout_r", int'(dout_r), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        sb.delete();
        run(3, 190, 1'b0, 0);

        for (int a = 1; a < 569; a++)
            run(a, inv_model(a), 1'b0, int'($urandom_range(0, 3)));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
